// File: rtl/axi4_burst_master_if.sv
// rtl/axi4_burst_master_if.sv - AXI4 burst master bus bundle (AW/W/B/AR/R channels) with master/slave views.
interface axi4_burst_master_if #(parameter int ID_WIDTH = 4) ();
  logic                aw_valid;
  logic                aw_ready;
  logic [ID_WIDTH-1:0] aw_id;
  logic [31:0]         aw_addr;
  logic [7:0]          aw_len;
  logic [2:0]          aw_size;
  logic [1:0]          aw_burst;

  logic                w_valid;
  logic                w_ready;
  logic [63:0]         w_data;
  logic [7:0]          w_strb;
  logic                w_last;

  logic                b_valid;
  logic                b_ready;
  logic [ID_WIDTH-1:0] b_id;
  logic [1:0]          b_resp;

  logic                ar_valid;
  logic                ar_ready;
  logic [ID_WIDTH-1:0] ar_id;
  logic [31:0]         ar_addr;
  logic [7:0]          ar_len;
  logic [2:0]          ar_size;
  logic [1:0]          ar_burst;

  logic                r_valid;
  logic                r_ready;
  logic [ID_WIDTH-1:0] r_id;
  logic [63:0]         r_data;
  logic [1:0]          r_resp;
  logic                r_last;

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_id, b_resp,
    output b_ready,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    input  ar_ready,
    input  r_valid, r_id, r_data, r_resp, r_last,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_id, b_resp,
    input  b_ready,
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    output ar_ready,
    output r_valid, r_id, r_data, r_resp, r_last,
    input  r_ready
  );
endinterface

// File: rtl/axi4_burst_master.sv
// rtl/axi4_burst_master.sv - single-outstanding AXI4 INCR burst initiator with 4KB guard and handshake watchdog.
// Optional macro AXI_MASTER_ADDR_MASK_EN applies ADDR_MASK to outgoing burst addresses.
module axi4_burst_master #(
  parameter int          ID_WIDTH    = 4,
  parameter int          AXI_ID      = 0,
  parameter logic [31:0] ADDR_MASK   = 32'h07ffffff,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,

  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [63:0] wr_data,
  input  logic [7:0]  wr_strb,

  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [63:0] rd_data,
  output logic        rd_last,

  output logic        done_valid,
  output logic [1:0]  done_resp,
  output logic        busy,
  output logic        timeout,

  axi4_burst_master_if.master io_axi4_0
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AW   = 3'd1;
  localparam logic [2:0] S_W    = 3'd2;
  localparam logic [2:0] S_B    = 3'd3;
  localparam logic [2:0] S_AR   = 3'd4;
  localparam logic [2:0] S_R    = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ID_WIDTH-1:0] OWN_ID = ID_WIDTH'(AXI_ID);

  logic [2:0]      state;
  logic [31:0]     addr_q;
  logic [7:0]      len_q;
  logic [7:0]      beat_cnt;
  logic [1:0]      resp_q;
  logic            err_q;
  logic [1:0]      done_resp_q;
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  logic [31:0] addr_bus;
  logic [13:0] span_end;
  logic        crosses_4k;
  logic        accept;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs;
  logic        last_beat;
  logic        r_proto_err;
  logic [1:0]  resp_n;
  logic        err_n;
  logic        unused_bits;

`ifdef AXI_MASTER_ADDR_MASK_EN
  assign addr_bus = {cmd_addr[31:3], 3'b000} & ADDR_MASK;
`else
  assign addr_bus = {cmd_addr[31:3], 3'b000};
`endif

  // End offset of the burst within its 4KB page; beyond 4096 the burst would straddle pages.
  assign span_end    = {2'b00, addr_bus[11:0]} + ((14'(cmd_len) + 14'd1) << 3);
  assign crosses_4k  = span_end > 14'd4096;
  assign unused_bits = ^{cmd_addr[2:0]};

  assign accept    = cmd_valid && (state == S_IDLE);
  assign last_beat = (beat_cnt == len_q);

  assign aw_hs  = io_axi4_0.aw_valid && io_axi4_0.aw_ready;
  assign w_hs   = io_axi4_0.w_valid  && io_axi4_0.w_ready;
  assign b_hs   = io_axi4_0.b_valid  && io_axi4_0.b_ready;
  assign ar_hs  = io_axi4_0.ar_valid && io_axi4_0.ar_ready;
  assign r_hs   = io_axi4_0.r_valid  && io_axi4_0.r_ready;
  assign any_hs = aw_hs || w_hs || b_hs || ar_hs || r_hs;

  always_comb begin
    r_proto_err = 1'b0;
    resp_n      = resp_q;
    err_n       = err_q;
    // A misplaced or missing r_last, or a foreign ID, means the slave lost track of the burst.
    r_proto_err = (io_axi4_0.r_last != last_beat) || (io_axi4_0.r_id != OWN_ID);
    if (io_axi4_0.r_resp > resp_q) begin
      resp_n = io_axi4_0.r_resp;
    end
    err_n = err_q || r_proto_err;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      addr_q      <= 32'd0;
      len_q       <= 8'd0;
      beat_cnt    <= 8'd0;
      resp_q      <= 2'b00;
      err_q       <= 1'b0;
      done_resp_q <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q   <= addr_bus;
            len_q    <= cmd_len;
            beat_cnt <= 8'd0;
            resp_q   <= 2'b00;
            err_q    <= 1'b0;
            if (crosses_4k) begin
              state       <= S_DONE;
              done_resp_q <= 2'b10;
            end else begin
              state <= cmd_write ? S_AW : S_AR;
            end
          end
        end
        S_AW: if (aw_hs) state <= S_W;
        S_W: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (last_beat) state <= S_B;
          end
        end
        S_B: begin
          if (b_hs) begin
            done_resp_q <= (io_axi4_0.b_id != OWN_ID) ? 2'b10 : io_axi4_0.b_resp;
            state       <= S_DONE;
          end
        end
        S_AR: if (ar_hs) state <= S_R;
        S_R: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            resp_q   <= resp_n;
            err_q    <= err_n;
            if (io_axi4_0.r_last) begin
              done_resp_q <= err_n ? 2'b10 : resp_n;
              state       <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Watchdog only observes; a stalled slave is flagged but the burst is left to finish.
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == S_IDLE || any_hs) begin
        wd_cnt <= '0;
      end else if (wd_cnt != WD_W'(TIMEOUT_CYC)) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (wd_cnt == WD_W'(TIMEOUT_CYC)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign cmd_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign done_valid = (state == S_DONE);
  assign done_resp  = done_resp_q;
  assign timeout    = timeout_q;

  assign io_axi4_0.aw_valid = (state == S_AW);
  assign io_axi4_0.aw_id    = OWN_ID;
  assign io_axi4_0.aw_addr  = addr_q;
  assign io_axi4_0.aw_len   = len_q;
  assign io_axi4_0.aw_size  = 3'b011;
  assign io_axi4_0.aw_burst = 2'b01;

  assign io_axi4_0.w_valid  = (state == S_W) && wr_valid;
  assign io_axi4_0.w_data   = wr_data;
  assign io_axi4_0.w_strb   = wr_strb;
  assign io_axi4_0.w_last   = last_beat;
  assign wr_ready           = (state == S_W) && io_axi4_0.w_ready;

  assign io_axi4_0.b_ready  = (state == S_B);

  assign io_axi4_0.ar_valid = (state == S_AR);
  assign io_axi4_0.ar_id    = OWN_ID;
  assign io_axi4_0.ar_addr  = addr_q;
  assign io_axi4_0.ar_len   = len_q;
  assign io_axi4_0.ar_size  = 3'b011;
  assign io_axi4_0.ar_burst = 2'b01;

  assign io_axi4_0.r_ready  = (state == S_R) && rd_ready;
  assign rd_valid           = (state == S_R) && io_axi4_0.r_valid;
  assign rd_data            = io_axi4_0.r_data;
  assign rd_last            = (state == S_R) && io_axi4_0.r_last;

endmodule
